// File: rtl/sandwich_order_if.sv
// Order bus between the button front end / sandwich checker and sandwich_order_ctrl.
// master: pulse source plus checker (drives v); slave: the order controller.
interface sandwich_order_if #(
  parameter int CNT_W = 8
);
  logic             sel_b;
  logic             sel_h;
  logic             sel_s;
  logic             submit;
  logic             clear;
  logic             v;
  logic             B;
  logic             H;
  logic             S;
  logic             busy;
  logic             accept;
  logic             reject;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;

  modport master (
    output sel_b, sel_h, sel_s, submit, clear, v,
    input  B, H, S, busy, accept, reject, good_cnt, bad_cnt
  );

  modport slave (
    input  sel_b, sel_h, sel_s, submit, clear, v,
    output B, H, S, busy, accept, reject, good_cnt, bad_cnt
  );
endinterface

// File: rtl/sandwich_order_ctrl.sv
// Sequential front end for the sandwich checker: collects B/H/S toggles, checks on submit,
// shows accept/reject for HOLD_CYC cycles and counts orders. Define SANDWICH_CNT_SAT_EN for saturating counters.
module sandwich_order_ctrl #(
  parameter int CNT_W    = 8,
  parameter int HOLD_CYC = 4
) (
  input logic             clk,
  input logic             rst,
  sandwich_order_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       HOLD_TOP = 8'(HOLD_CYC - 1);

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic [7:0]       hold_q, hold_d;
  logic             accept_q, accept_d;
  logic             reject_q, reject_d;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
`ifdef SANDWICH_CNT_SAT_EN
    return (&cnt) ? cnt : cnt + CNT_ONE;
`else
    return cnt + CNT_ONE;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 3'b000;
      good_q   <= '0;
      bad_q    <= '0;
      hold_q   <= 8'd0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      hold_q   <= hold_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    good_d   = good_q;
    bad_d    = bad_q;
    hold_d   = hold_q;
    accept_d = accept_q;
    reject_d = reject_q;
    unique case (state_q)
      IDLE: begin
        // clear beats submit beats toggles; toggles with submit are dropped
        if (bus.clear) begin
          sel_d  = 3'b000;
          good_d = '0;
          bad_d  = '0;
        end else if (bus.submit) begin
          state_d = CHECK;
        end else begin
          sel_d = sel_q ^ {bus.sel_b, bus.sel_h, bus.sel_s};
        end
      end
      CHECK: begin
        hold_d  = HOLD_TOP;
        state_d = SHOW;
        if (bus.v) begin
          accept_d = 1'b1;
          good_d   = cnt_inc(good_q);
        end else begin
          reject_d = 1'b1;
          bad_d    = cnt_inc(bad_q);
        end
      end
      SHOW: begin
        if (hold_q == 8'd0) begin
          state_d  = IDLE;
          accept_d = 1'b0;
          reject_d = 1'b0;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.B        = sel_q[2];
  assign bus.H        = sel_q[1];
  assign bus.S        = sel_q[0];
  assign bus.busy     = (state_q != IDLE);
  assign bus.accept   = accept_q;
  assign bus.reject   = reject_q;
  assign bus.good_cnt = good_q;
  assign bus.bad_cnt  = bad_q;

endmodule

// File: tb/tb_sandwich_order_ctrl.sv
// Self-checking bench for sandwich_order_ctrl: directed vector table, corner sequences,
// and randomized pulses against an order-level reference model.
module tb_sandwich_order_ctrl;
  localparam int HOLD = 4;
  localparam int CW   = 8;

  typedef struct packed {
    logic [4:0]  stim;  // {sel_b, sel_h, sel_s, submit, clear}
    logic [21:0] exp;   // {B,H,S, busy, accept, reject, good_cnt, bad_cnt}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sandwich_order_if #(.CNT_W(CW)) bus ();
  assign bus.v = bus.B & (bus.H | bus.S);

  sandwich_order_ctrl #(.CNT_W(CW), .HOLD_CYC(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model state: order-level view, t = cycles of busy still to come
  logic [2:0]    m_sel;
  logic [CW-1:0] m_g, m_b;
  int            m_t;
  logic          m_ver;

  function automatic logic [21:0] outs();
    return {bus.B, bus.H, bus.S, bus.busy, bus.accept, bus.reject, bus.good_cnt, bus.bad_cnt};
  endfunction

  function automatic vec_t mk(input logic [4:0] st, input logic [2:0] bhs, input logic bz,
                              input logic ac, input logic rj, input int g, input int b);
    vec_t r;
    r.stim = st;
    r.exp  = {bhs, bz, ac, rj, 8'(g), 8'(b)};
    return r;
  endfunction

  function automatic logic [CW-1:0] m_inc(input logic [CW-1:0] c);
`ifdef SANDWICH_CNT_SAT_EN
    return (c == 8'd255) ? c : c + 8'd1;
`else
    return c + 8'd1;
`endif
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got BHS=%b busy=%b acc=%b rej=%b good=%0d bad=%0d, expected BHS=%b busy=%b acc=%b rej=%b good=%0d bad=%0d",
               name, act[21:19], act[18], act[17], act[16], act[15:8], act[7:0],
               exp[21:19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
    end else begin
      $display("ok   %s: BHS=%b busy=%b acc=%b rej=%b good=%0d bad=%0d",
               name, act[21:19], act[18], act[17], act[16], act[15:8], act[7:0]);
    end
  endtask

  // apply one cycle of pulses, then sample on the falling edge
  task automatic drive(input logic [4:0] st);
    {bus.sel_b, bus.sel_h, bus.sel_s, bus.submit, bus.clear} = st;
    @(posedge clk);
    @(negedge clk);
    {bus.sel_b, bus.sel_h, bus.sel_s, bus.submit, bus.clear} = 5'b0;
  endtask

  task automatic model_step(input logic r, input logic [4:0] st);
    if (r) begin
      m_sel = 3'b0; m_g = '0; m_b = '0; m_t = 0; m_ver = 1'b0;
    end else if (m_t > 0) begin
      m_t--;
      if (m_t == HOLD) begin
        if (m_ver) m_g = m_inc(m_g);
        else       m_b = m_inc(m_b);
      end
    end else if (st[0]) begin
      m_sel = 3'b0; m_g = '0; m_b = '0;
    end else if (st[1]) begin
      m_ver = m_sel[2] & (m_sel[1] | m_sel[0]);
      m_t   = HOLD + 1;
    end else begin
      m_sel = m_sel ^ st[4:2];
    end
  endtask

  function automatic logic [21:0] model_outs();
    logic show;
    show = (m_t >= 1) && (m_t <= HOLD);
    return {m_sel, logic'(m_t > 0), show & m_ver, show & ~m_ver, m_g, m_b};
  endfunction

  vec_t vec[29];

  initial begin
    logic [CW-1:0] exp_lim;
    {bus.sel_b, bus.sel_h, bus.sel_s, bus.submit, bus.clear} = 5'b0;

    // valid order, invalid order, events during SHOW, simultaneous events, clear
    vec[0]  = mk(5'b10000, 3'b100, 0, 0, 0, 0, 0);
    vec[1]  = mk(5'b01000, 3'b110, 0, 0, 0, 0, 0);
    vec[2]  = mk(5'b00010, 3'b110, 1, 0, 0, 0, 0);
    vec[3]  = mk(5'b00000, 3'b110, 1, 1, 0, 1, 0);
    vec[4]  = mk(5'b00000, 3'b110, 1, 1, 0, 1, 0);
    vec[5]  = mk(5'b00000, 3'b110, 1, 1, 0, 1, 0);
    vec[6]  = mk(5'b00000, 3'b110, 1, 1, 0, 1, 0);
    vec[7]  = mk(5'b00000, 3'b110, 0, 0, 0, 1, 0);
    vec[8]  = mk(5'b10000, 3'b010, 0, 0, 0, 1, 0);
    vec[9]  = mk(5'b00010, 3'b010, 1, 0, 0, 1, 0);
    vec[10] = mk(5'b00000, 3'b010, 1, 0, 1, 1, 1);
    vec[11] = mk(5'b00000, 3'b010, 1, 0, 1, 1, 1);
    vec[12] = mk(5'b00000, 3'b010, 1, 0, 1, 1, 1);
    vec[13] = mk(5'b00000, 3'b010, 1, 0, 1, 1, 1);
    vec[14] = mk(5'b00000, 3'b010, 0, 0, 0, 1, 1);
    vec[15] = mk(5'b00100, 3'b011, 0, 0, 0, 1, 1);
    vec[16] = mk(5'b00010, 3'b011, 1, 0, 0, 1, 1);
    vec[17] = mk(5'b00110, 3'b011, 1, 0, 1, 1, 2);
    vec[18] = mk(5'b00001, 3'b011, 1, 0, 1, 1, 2);
    vec[19] = mk(5'b00000, 3'b011, 1, 0, 1, 1, 2);
    vec[20] = mk(5'b00000, 3'b011, 1, 0, 1, 1, 2);
    vec[21] = mk(5'b00000, 3'b011, 0, 0, 0, 1, 2);
    vec[22] = mk(5'b10110, 3'b011, 1, 0, 0, 1, 2);
    vec[23] = mk(5'b00000, 3'b011, 1, 0, 1, 1, 3);
    vec[24] = mk(5'b00000, 3'b011, 1, 0, 1, 1, 3);
    vec[25] = mk(5'b00000, 3'b011, 1, 0, 1, 1, 3);
    vec[26] = mk(5'b00000, 3'b011, 1, 0, 1, 1, 3);
    vec[27] = mk(5'b00000, 3'b011, 0, 0, 0, 1, 3);
    vec[28] = mk(5'b00001, 3'b000, 0, 0, 0, 0, 0);

    // reset: two cycles high, then low
    rst = 1'b1;
    drive(5'b0);
    drive(5'b0);
    check("reset_held", outs(), 22'd0);
    rst = 1'b0;
    drive(5'b0);
    check("reset_release", outs(), 22'd0);

    for (int i = 0; i < 29; i++) begin
      drive(vec[i].stim);
      check($sformatf("vec%0d", i), outs(), vec[i].exp);
    end

    // reset during SHOW
    drive(5'b10000);
    drive(5'b01000);
    drive(5'b00010);
    drive(5'b00000);
    drive(5'b00000);
    check("pre_rst_show", outs(), {3'b110, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0});
    rst = 1'b1;
    drive(5'b0);
    rst = 1'b0;
    check("rst_mid_show", outs(), 22'd0);

    // clear after a completed order
    drive(5'b01000);
    drive(5'b00010);
    repeat (HOLD + 1) drive(5'b0);
    check("pre_clear", outs(), {3'b010, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1});
    drive(5'b00001);
    check("clear", outs(), 22'd0);

    // counter limit: 256 valid orders
    drive(5'b10000);
    drive(5'b01000);
    for (int k = 1; k <= 256; k++) begin
      drive(5'b00010);
      repeat (HOLD + 1) drive(5'b0);
      if (k == 255) check("good_cnt_255", outs(), {3'b110, 1'b0, 1'b0, 1'b0, 8'd255, 8'd0});
    end
`ifdef SANDWICH_CNT_SAT_EN
    exp_lim = 8'd255;
`else
    exp_lim = 8'd0;
`endif
    check("good_cnt_limit", outs(), {3'b110, 1'b0, 1'b0, 1'b0, exp_lim, 8'd0});

    // randomized pulses against the reference model
    rst = 1'b1;
    drive(5'b0);
    model_step(1'b1, 5'b0);
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] st;
      logic       r;
      st[4] = ($urandom_range(0, 3) == 0);
      st[3] = ($urandom_range(0, 3) == 0);
      st[2] = ($urandom_range(0, 3) == 0);
      st[1] = ($urandom_range(0, 5) == 0);
      st[0] = ($urandom_range(0, 39) == 0);
      r     = ($urandom_range(0, 199) == 0);
      rst   = r;
      drive(st);
      rst   = 1'b0;
      model_step(r, st);
      check($sformatf("rand%0d", c), outs(), model_outs());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
